// File: rtl/bcd_display_seq_pkg.sv
// Shared types and constants for the sequential BCD display driver.
// Exposes the FSM state enum, segment codes and the pow10 threshold helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FIN
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++)
         r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_display_seq_if.sv
// Request/result bundle of the BCD display driver.
// master: start, bin out; slave: busy, done, ovf, bcd, hex out.
interface bcd_display_seq_if #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [WIDTH-1:0]      bin;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   hex;

   modport master (
      output start, bin,
      input  busy, done, ovf, bcd, hex
   );

   modport slave (
      input  start, bin,
      output busy, done, ovf, bcd, hex
   );
endinterface

// File: rtl/bcd_display_seq_digit.sv
// Per-digit segment driver: hex_to_7seg decoder plus blank/dash override.
// Ports: digit (4b), blank, dash (dash wins) -> seg (7b, active-low).
module hex_to_7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'b1111111;
      unique case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'ha: seg = 7'b0001000;
         4'hb: seg = 7'b0000011;
         4'hc: seg = 7'b1000110;
         4'hd: seg = 7'b0100001;
         4'he: seg = 7'b0000110;
         4'hf: seg = 7'b0001110;
      endcase
   end
endmodule

module bcd_digit_seg
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);
   logic [6:0] raw;

   hex_to_7seg u_dec (
      .hex (digit),
      .seg (raw)
   );

   always_comb begin
      seg = raw;
      if (dash)
         seg = SEG_DASH;
      else if (blank)
         seg = SEG_BLANK;
   end
endmodule

// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with 7-seg output.
// Ports: clk, rst (sync, high); bus: start/bin in, busy/done/ovf/bcd/hex out.
module bcd_display_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int DIGITS   = 4,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   bcd_display_seq_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;
   localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

   state_t           state, state_n;
   logic [WIDTH-1:0] sh, sh_n;
   logic [BW-1:0]    work, work_n, adj, step;
   logic [BW-1:0]    bcd_q, bcd_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             ovfp, ovfp_n;
   logic             ovf_q, ovf_n;
   logic             load;

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = work[4*i +: 4];
      end
   end

   // Top digit carry drops out here, giving bin mod 10^DIGITS.
   assign step = {adj[BW-2:0], sh[WIDTH-1]};

   always_comb begin
      state_n = state;
      sh_n    = sh;
      work_n  = work;
      cnt_n   = cnt;
      ovfp_n  = ovfp;
      bcd_n   = bcd_q;
      ovf_n   = ovf_q;
      load    = 1'b0;
      unique case (state)
         IDLE: load = bus.start;
         SHIFT: begin
            sh_n   = sh << 1;
            work_n = step;
            cnt_n  = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               bcd_n   = step;
               ovf_n   = ovfp;
               state_n = FIN;
            end
         end
         FIN: begin
            load    = bus.start;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (load) begin
         sh_n    = bus.bin;
         work_n  = '0;
         cnt_n   = CW'(WIDTH);
         ovfp_n  = 64'(bus.bin) > LIMIT;
         state_n = SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         work  <= '0;
         cnt   <= '0;
         ovfp  <= 1'b0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         work  <= work_n;
         cnt   <= cnt_n;
         ovfp  <= ovfp_n;
         bcd_q <= bcd_n;
         ovf_q <= ovf_n;
      end
   end

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == FIN);
   assign bus.ovf  = ovf_q;
   assign bus.bcd  = bcd_q;

   // zab[i]: digits i..DIGITS-1 are all zero.
   logic [DIGITS:0]   zab;
   logic [DIGITS-1:0] blank;
   logic [7*DIGITS-1:0] hex;

   always_comb begin
      zab[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--)
         zab[i] = zab[i+1] & (bcd_q[4*i +: 4] == 4'd0);
      blank = '0;
      for (int i = 1; i < DIGITS; i++)
         blank[i] = BLANK_LZ & zab[i];
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_seg u_dig (
         .digit (bcd_q[4*g +: 4]),
         .blank (blank[g]),
         .dash  (ovf_q),
         .seg   (hex[7*g +: 7])
      );
   end

   assign bus.hex = hex;
endmodule

// File: tb/tb_bcd_display_seq.sv
// Bench for bcd_display_seq: three configs driven in lockstep.
// Scoreboard of submitted values, checked when DONE fires.
module tb_bcd_display_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_display_seq_if #(.WIDTH(10), .DIGITS(4)) bus0 ();
   bcd_display_seq_if #(.WIDTH(10), .DIGITS(4)) bus1 ();
   bcd_display_seq_if #(.WIDTH(10), .DIGITS(2)) bus2 ();

   bcd_display_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b1)) u0 (
      .clk (clk), .rst (rst), .bus (bus0.slave));
   bcd_display_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b0)) u1 (
      .clk (clk), .rst (rst), .bus (bus1.slave));
   bcd_display_seq #(.WIDTH(10), .DIGITS(2), .BLANK_LZ(1'b1)) u2 (
      .clk (clk), .rst (rst), .bus (bus2.slave));

   int vec  = 0;
   int miss = 0;
   int sb[$];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vec++;
      assert (obs === exp)
      else begin
         miss++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [15:0] bcd_of(int v, int digits);
      logic [15:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit ovf_of(int v, int digits);
      int lim;
      lim = 1;
      for (int i = 0; i < digits; i++)
         lim = lim * 10;
      return v > lim - 1;
   endfunction

   function automatic logic [27:0] hex_of(logic [15:0] b, int digits,
                                          bit ovf, bit blz);
      logic [27:0] r;
      int hi;
      r  = '0;
      hi = 0;
      for (int i = 0; i < digits; i++)
         if (b[4*i +: 4] != 4'd0)
            hi = i;
      for (int i = 0; i < digits; i++) begin
         if (ovf)
            r[7*i +: 7] = 7'b0111111;
         else if (blz && i > hi)
            r[7*i +: 7] = 7'b1111111;
         else
            r[7*i +: 7] = seg_of(b[4*i +: 4]);
      end
      return r;
   endfunction

   task automatic drive(logic s, int v);
      bus0.start = s;
      bus1.start = s;
      bus2.start = s;
      bus0.bin   = 10'(v);
      bus1.bin   = 10'(v);
      bus2.bin   = 10'(v);
   endtask

   task automatic go(int v);
      drive(1'b1, v);
      sb.push_back(v);
      @(negedge clk);
      drive(1'b0, 0);
   endtask

   task automatic wait_done(output int bc, output bit ok);
      bc = 0;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (bus0.done) begin
            ok = 1'b1;
            break;
         end
         if (bus0.busy)
            bc++;
         @(negedge clk);
      end
   endtask

   task automatic check_reset(string tag);
      chk({tag, "_bcd0"}, bus0.bcd, 16'h0000);
      chk({tag, "_busy0"}, bus0.busy, 1'b0);
      chk({tag, "_done0"}, bus0.done, 1'b0);
      chk({tag, "_ovf0"}, bus0.ovf, 1'b0);
      chk({tag, "_hex0"}, bus0.hex, 28'hFFFFFC0);
      chk({tag, "_hex1"}, bus1.hex, {4{7'b1000000}});
      chk({tag, "_hex2"}, bus2.hex, 14'h3FC0);
      chk({tag, "_bcd2"}, bus2.bcd, 8'h00);
   endtask

   task automatic check_result(string tag);
      int v;
      logic [15:0] b4, b2;
      bit o2;
      chk({tag, "_sb"}, sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
         v  = sb.pop_front();
         b4 = bcd_of(v, 4);
         b2 = bcd_of(v, 2);
         o2 = ovf_of(v, 2);
         chk({tag, "_bcd0"}, bus0.bcd, b4);
         chk({tag, "_ovf0"}, bus0.ovf, ovf_of(v, 4));
         chk({tag, "_hex0"}, bus0.hex, hex_of(b4, 4, 1'b0, 1'b1));
         chk({tag, "_busy0"}, bus0.busy, 1'b0);
         chk({tag, "_hex1"}, bus1.hex, hex_of(b4, 4, 1'b0, 1'b0));
         chk({tag, "_done1"}, bus1.done, 1'b1);
         chk({tag, "_bcd2"}, bus2.bcd, b2[7:0]);
         chk({tag, "_ovf2"}, bus2.ovf, o2);
         chk({tag, "_hex2"}, bus2.hex, hex_of(b2, 2, o2, 1'b1) & 28'h3FFF);
      end
   endtask

   task automatic convert(string tag, int v, int exp_bc);
      int bc;
      bit ok;
      go(v);
      wait_done(bc, ok);
      chk({tag, "_done_seen"}, ok, 1'b1);
      chk({tag, "_busy_cycles"}, bc, exp_bc);
      check_result(tag);
   endtask

   initial begin
      int bc;
      bit ok;
      int seen;
      rst = 1'b1;
      drive(1'b0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset("reset");

      @(negedge clk);
      convert("c1023", 1023, 10);
      @(negedge clk);
      chk("c1023_done_drop", bus0.done, 1'b0);

      convert("c7", 7, 10);
      @(negedge clk);
      convert("c0", 0, 10);
      @(negedge clk);
      convert("c100", 100, 10);
      @(negedge clk);

      go(512);
      repeat (3) @(negedge clk);
      bus0.start = 1'b1;
      bus1.start = 1'b1;
      bus2.start = 1'b1;
      bus0.bin = 10'd99;
      bus1.bin = 10'd99;
      bus2.bin = 10'd99;
      @(negedge clk);
      drive(1'b0, 0);
      wait_done(bc, ok);
      chk("c512_done_seen", ok, 1'b1);
      chk("c512_busy_rest", bc, 6);
      check_result("c512");
      convert("c99_b2b", 99, 10);
      @(negedge clk);

      convert("c250", 250, 10);
      @(negedge clk);
      convert("c42", 42, 10);
      @(negedge clk);

      go(1000);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      check_reset("rst_mid");
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus0.done || bus0.busy)
            seen++;
         @(negedge clk);
      end
      chk("rst_mid_quiet", seen, 0);

      rst = 1'b1;
      drive(1'b1, 5);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 0);
      check_reset("rst_start");
      @(negedge clk);
      chk("rst_start_busy", bus0.busy, 1'b0);

      convert("c999", 999, 10);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
